// File: rtl/omap_gpmc_sync_bus.sv
// omap_gpmc_sync_bus: synchronous OMAP GPMC slave bridging processor accesses
// onto the internal host register bus.
//
// Ports:
//   omap_gpmc_clk, host_rst_l         clock, async active-low reset
//   omap_cs_l/oe_l/wr_l, omap_a       GPMC strobes and word address
//   omap_d_in / omap_d_out, omap_d_oe pad data in/out and driver enable
//   omap_wait                         active-high stall to the processor
//   host_addr, host_wr_data           {page, base+beat} and write data
//   host_wr_en / host_rd_en           one-cycle strobes per beat
//   host_rd_data, host_rd_valid       read return from host
//   bus_err                           sticky read-timeout flag
//   sys_rst_l                         soft reset to the rest of the FPGA
//
// Build option: define GPMC_SOFT_RESET_EN to make a write beat to RESET_ADDR
// hold sys_rst_l low until chip select is released. Without it sys_rst_l
// stays at 1 and RESET_ADDR is an ordinary register address.
module omap_gpmc_sync_bus #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned PAGE_W     = 12,
  parameter int unsigned PAGE_ADDR  = 0,
  parameter int unsigned RESET_ADDR = 1,
  parameter int unsigned WAIT_MAX   = 15
) (
  input  logic                     omap_gpmc_clk,
  input  logic                     host_rst_l,
  input  logic                     omap_cs_l,
  input  logic                     omap_oe_l,
  input  logic                     omap_wr_l,
  input  logic [ADDR_W-1:0]        omap_a,
  input  logic [DATA_W-1:0]        omap_d_in,
  output logic [DATA_W-1:0]        omap_d_out,
  output logic                     omap_d_oe,
  output logic                     omap_wait,
  output logic [PAGE_W+ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0]        host_wr_data,
  output logic                     host_wr_en,
  output logic                     host_rd_en,
  input  logic [DATA_W-1:0]        host_rd_data,
  input  logic                     host_rd_valid,
  output logic                     bus_err,
  output logic                     sys_rst_l
);

  localparam int unsigned HADDR_W = PAGE_W + ADDR_W;
  localparam int unsigned CNT_W   = 8;

  localparam logic [ADDR_W-1:0] PAGE_LO  = ADDR_W'(PAGE_ADDR);
  localparam logic [ADDR_W-1:0] RST_LO   = ADDR_W'(RESET_ADDR);
  localparam logic [CNT_W-1:0]  WAIT_LIM = CNT_W'(WAIT_MAX);

`ifdef GPMC_SOFT_RESET_EN
  localparam bit SOFT_RST_EN = 1'b1;
`else
  localparam bit SOFT_RST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DRIVE   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HADDR_W-1:0]  host_addr_q, host_addr_d;
  logic [DATA_W-1:0]   host_wr_data_q, host_wr_data_d;
  logic                host_wr_en_q, host_wr_en_d;
  logic                host_rd_en_q, host_rd_en_d;
  logic [DATA_W-1:0]   omap_d_out_q, omap_d_out_d;
  logic                omap_wait_q, omap_wait_d;
  logic                bus_err_q, bus_err_d;
  logic                sys_rst_l_q, sys_rst_l_d;

  logic [ADDR_W-1:0]   addr_lo;
  logic [ADDR_W-1:0]   wr_lo;
  logic [CNT_W-1:0]    cnt_inc;
  logic                wr_beat;

  // Current beat address within the page; wraps, never carries into page.
  assign addr_lo = base_q + beat_q;
  // First write beat is taken straight from the pins while still in IDLE.
  assign wr_lo   = (state_q == IDLE) ? omap_a : addr_lo;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // State register.
  always_ff @(posedge omap_gpmc_clk or negedge host_rst_l) begin
    if (!host_rst_l) begin
      state_q        <= IDLE;
      page_q         <= '0;
      base_q         <= '0;
      beat_q         <= '0;
      cnt_q          <= '0;
      host_addr_q    <= '0;
      host_wr_data_q <= '0;
      host_wr_en_q   <= 1'b0;
      host_rd_en_q   <= 1'b0;
      omap_d_out_q   <= '0;
      omap_wait_q    <= 1'b0;
      bus_err_q      <= 1'b0;
      sys_rst_l_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      page_q         <= page_d;
      base_q         <= base_d;
      beat_q         <= beat_d;
      cnt_q          <= cnt_d;
      host_addr_q    <= host_addr_d;
      host_wr_data_q <= host_wr_data_d;
      host_wr_en_q   <= host_wr_en_d;
      host_rd_en_q   <= host_rd_en_d;
      omap_d_out_q   <= omap_d_out_d;
      omap_wait_q    <= omap_wait_d;
      bus_err_q      <= bus_err_d;
      sys_rst_l_q    <= sys_rst_l_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    page_d         = page_q;
    base_d         = base_q;
    beat_d         = beat_q;
    cnt_d          = cnt_q;
    host_addr_d    = host_addr_q;
    host_wr_data_d = host_wr_data_q;
    host_wr_en_d   = 1'b0;
    host_rd_en_d   = 1'b0;
    omap_d_out_d   = omap_d_out_q;
    omap_wait_d    = omap_wait_q;
    bus_err_d      = bus_err_q;
    sys_rst_l_d    = sys_rst_l_q;
    wr_beat        = 1'b0;

    if (omap_cs_l) begin
      // Chip select released: abandon whatever was in flight.
      state_d     = IDLE;
      beat_d      = '0;
      omap_wait_d = 1'b0;
      sys_rst_l_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!omap_wr_l) begin
            base_d  = omap_a;
            beat_d  = ADDR_W'(1);
            state_d = WRITE;
            wr_beat = 1'b1;
          end else if (!omap_oe_l) begin
            base_d  = omap_a;
            beat_d  = '0;
            state_d = RD_REQ;
          end
        end
        WRITE: begin
          if (!omap_wr_l) begin
            beat_d  = beat_q + ADDR_W'(1);
            wr_beat = 1'b1;
          end
        end
        RD_REQ: begin
          host_rd_en_d = 1'b1;
          omap_wait_d  = 1'b1;
          cnt_d        = '0;
          host_addr_d  = {page_q, addr_lo};
          state_d      = RD_WAIT;
        end
        RD_WAIT: begin
          if (host_rd_valid) begin
            omap_d_out_d = host_rd_data;
            omap_wait_d  = 1'b0;
            state_d      = DRIVE;
          end else if (cnt_inc == WAIT_LIM) begin
            omap_d_out_d = '1;
            bus_err_d    = 1'b1;
            omap_wait_d  = 1'b0;
            state_d      = DRIVE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DRIVE: begin
          if (!omap_oe_l) begin
            beat_d  = beat_q + ADDR_W'(1);
            state_d = RD_REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Forward a write beat; page/reset decode uses the old page in host_addr.
    if (wr_beat) begin
      host_wr_en_d   = 1'b1;
      host_addr_d    = {page_q, wr_lo};
      host_wr_data_d = omap_d_in;
      if (wr_lo == PAGE_LO) begin
        page_d = omap_d_in[PAGE_W-1:0];
      end
      if (SOFT_RST_EN && (wr_lo == RST_LO)) begin
        sys_rst_l_d = 1'b0;
      end
    end
  end

  assign omap_d_out   = omap_d_out_q;
  assign omap_d_oe    = ~omap_cs_l & ~omap_oe_l & (state_q == DRIVE);
  assign omap_wait    = omap_wait_q;
  assign host_addr    = host_addr_q;
  assign host_wr_data = host_wr_data_q;
  assign host_wr_en   = host_wr_en_q;
  assign host_rd_en   = host_rd_en_q;
  assign bus_err      = bus_err_q;
  assign sys_rst_l    = sys_rst_l_q;

endmodule
